// File: rtl/ide_target.sv
// ATA/IDE device-side responder: task-file registers, strobe decode and single-sector
// READ SECTOR(S) / WRITE SECTOR(S) through a 256x16 buffer in front of a word-addressed store.
module ide_target #(
    parameter int unsigned LBA_BITS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [15:0]           ide_data_bus,
    input  logic                  ide_dior,
    input  logic                  ide_diow,
    input  logic [1:0]            ide_cs,
    input  logic [2:0]            ide_da,
    output logic [LBA_BITS+7:0]   store_addr,
    output logic                  store_rd,
    output logic                  store_wr,
    output logic [15:0]           store_out,
    input  logic [15:0]           store_in,
    input  logic                  store_ack,
    output logic                  busy
);

    // {cs, da} register codes
    localparam logic [4:0] RegData    = 5'b10000;
    localparam logic [4:0] RegErr     = 5'b10001;
    localparam logic [4:0] RegSecCnt  = 5'b10010;
    localparam logic [4:0] RegLbaLo   = 5'b10011;
    localparam logic [4:0] RegLbaMid  = 5'b10100;
    localparam logic [4:0] RegLbaHi   = 5'b10101;
    localparam logic [4:0] RegDrvHead = 5'b10110;
    localparam logic [4:0] RegStatus  = 5'b10111;
    localparam logic [4:0] RegCtrl    = 5'b01110;

    localparam logic [7:0] StatIdle  = 8'h50;
    localparam logic [7:0] StatBusy  = 8'hD0;
    localparam logic [7:0] StatDrq   = 8'h58;
    localparam logic [7:0] StatAbort = 8'h51;
    localparam logic [7:0] StatSrst  = 8'h80;
    localparam logic [7:0] CmdRead   = 8'h20;
    localparam logic [7:0] CmdWrite  = 8'h30;

    // Synchronizer word layout: {dior, diow, cs[1:0], da[2:0]}; idle = strobes/selects high
    localparam logic [6:0] SyncIdle = 7'b1111000;

    typedef enum logic [2:0] {
        StIdle, StDecode, StFetch, StXferIn, StXferOut, StFlush
    } state_e;

    logic [6:0]          sync_q [SYNC_STAGES];
    logic                dior_s, diow_s;
    logic [4:0]          addr_s;
    logic                dior_prev_q, diow_prev_q;
    logic                rd_rise, wr_rise;
    logic [4:0]          addr_q;
    logic [15:0]         wdata_q;

    state_e              state_q, state_d;
    logic [7:0]          status_q, status_d;
    logic [7:0]          error_q, error_d;
    logic [7:0]          feature_q, feature_d;
    logic [7:0]          seccnt_q, seccnt_d;
    logic [7:0]          lba_lo_q, lba_lo_d;
    logic [7:0]          lba_mid_q, lba_mid_d;
    logic [7:0]          lba_hi_q, lba_hi_d;
    logic [7:0]          drvhead_q, drvhead_d;
    logic [7:0]          command_q, command_d;
    logic [7:0]          devctrl_q, devctrl_d;
    logic                intrq_q, intrq_d;
    logic [7:0]          ptr_q, ptr_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [8:0]          cnt_inc;
    logic [LBA_BITS-1:0] cmd_lba_q, cmd_lba_d;
    logic                store_rd_q, store_rd_d;
    logic                store_wr_q, store_wr_d;
    logic [15:0]         store_out_q, store_out_d;

    logic [15:0]         buf_q [256];
    logic                buf_we;
    logic [15:0]         buf_wdata;

    logic [31:0]         lba32;
    logic                lba_ok;
    logic                cmd_valid;
    logic                rd_hit;
    logic [15:0]         rdata;
    logic                unused_regs;

    // Strobe, select and address synchronizer chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncIdle;
        end else begin
            sync_q[0] <= {ide_dior, ide_diow, ide_cs, ide_da};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign dior_s  = sync_q[SYNC_STAGES-1][6];
    assign diow_s  = sync_q[SYNC_STAGES-1][5];
    assign addr_s  = sync_q[SYNC_STAGES-1][4:0];
    assign rd_rise = dior_s & ~dior_prev_q;
    assign wr_rise = diow_s & ~diow_prev_q;

    // Edge history plus address/data captured while a strobe is low, used at the rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dior_prev_q <= 1'b1;
            diow_prev_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            dior_prev_q <= dior_s;
            diow_prev_q <= diow_s;
            if (!dior_s || !diow_s) addr_q <= addr_s;
            if (!diow_s) wdata_q <= ide_data_bus;
        end
    end

    assign lba32     = {8'h00, lba_hi_q, lba_mid_q, lba_lo_q};
    assign lba_ok    = (lba32 >> LBA_BITS) == 32'd0;
    assign cmd_valid = ((command_q == CmdRead) || (command_q == CmdWrite)) &&
                       (seccnt_q == 8'd1) && !drvhead_q[4] && lba_ok;
    assign cnt_inc   = cnt_q + 9'd1;

    // Host read mux; the bus is only driven for decoded addresses
    always_comb begin
        rd_hit = 1'b1;
        rdata  = 16'h0000;
        case (addr_s)
            RegData:             rdata = (state_q == StXferIn) ? buf_q[ptr_q] : 16'h0000;
            RegErr:              rdata = {8'h00, error_q};
            RegSecCnt:           rdata = {8'h00, seccnt_q};
            RegLbaLo:            rdata = {8'h00, lba_lo_q};
            RegLbaMid:           rdata = {8'h00, lba_mid_q};
            RegLbaHi:            rdata = {8'h00, lba_hi_q};
            RegDrvHead:          rdata = {8'h00, drvhead_q};
            RegStatus, RegCtrl:  rdata = {8'h00, status_q};
            default:             rd_hit = 1'b0;
        endcase
    end

    assign ide_data_bus = (!dior_s && rd_hit) ? rdata : 16'hzzzz;

    // Register writes, command FSM and store handshake
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        error_d     = error_q;
        feature_d   = feature_q;
        seccnt_d    = seccnt_q;
        lba_lo_d    = lba_lo_q;
        lba_mid_d   = lba_mid_q;
        lba_hi_d    = lba_hi_q;
        drvhead_d   = drvhead_q;
        command_d   = command_q;
        devctrl_d   = devctrl_q;
        intrq_d     = intrq_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        cmd_lba_d   = cmd_lba_q;
        store_rd_d  = store_rd_q;
        store_wr_d  = store_wr_q;
        store_out_d = store_out_q;
        buf_we      = 1'b0;
        buf_wdata   = wdata_q;

        if (wr_rise) begin
            if (addr_q == RegCtrl) begin
                devctrl_d = wdata_q[7:0];
            end else if (!status_q[7]) begin
                case (addr_q)
                    RegErr:     feature_d = wdata_q[7:0];
                    RegSecCnt:  seccnt_d  = wdata_q[7:0];
                    RegLbaLo:   lba_lo_d  = wdata_q[7:0];
                    RegLbaMid:  lba_mid_d = wdata_q[7:0];
                    RegLbaHi:   lba_hi_d  = wdata_q[7:0];
                    RegDrvHead: drvhead_d = wdata_q[7:0];
                    RegStatus: begin
                        command_d = wdata_q[7:0];
                        if (state_q == StIdle) begin
                            state_d  = StDecode;
                            status_d = StatBusy;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // altstatus reads leave the interrupt pending
        if (rd_rise && addr_q == RegStatus) intrq_d = 1'b0;

        case (state_q)
            StIdle: ;
            StDecode: begin
                ptr_d = 8'd0;
                cnt_d = 9'd0;
                if (cmd_valid) begin
                    error_d   = 8'h00;
                    cmd_lba_d = lba32[LBA_BITS-1:0];
                    if (command_q == CmdRead) begin
                        state_d = StFetch;
                    end else begin
                        state_d  = StXferOut;
                        status_d = StatDrq;
                    end
                end else begin
                    error_d  = 8'h04;
                    status_d = StatAbort;
                    intrq_d  = 1'b1;
                    state_d  = StIdle;
                end
            end
            StFetch: begin
                // Request drops for one clk after each ack so the new address is presented cleanly
                if (store_rd_q && store_ack) begin
                    buf_we     = 1'b1;
                    buf_wdata  = store_in;
                    store_rd_d = 1'b0;
                    ptr_d      = ptr_q + 8'd1;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == 9'd256) begin
                        cnt_d    = 9'd0;
                        state_d  = StXferIn;
                        status_d = StatDrq;
                        intrq_d  = 1'b1;
                    end
                end else begin
                    store_rd_d = 1'b1;
                end
            end
            StXferIn: begin
                if (rd_rise && addr_q == RegData) begin
                    ptr_d = ptr_q + 8'd1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == 9'd256) begin
                        cnt_d    = 9'd0;
                        state_d  = StIdle;
                        status_d = StatIdle;
                    end
                end
            end
            StXferOut: begin
                if (wr_rise && addr_q == RegData) begin
                    buf_we = 1'b1;
                    ptr_d  = ptr_q + 8'd1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == 9'd256) begin
                        cnt_d    = 9'd0;
                        state_d  = StFlush;
                        status_d = StatBusy;
                    end
                end
            end
            StFlush: begin
                if (store_wr_q && store_ack) begin
                    store_wr_d = 1'b0;
                    ptr_d      = ptr_q + 8'd1;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == 9'd256) begin
                        cnt_d    = 9'd0;
                        state_d  = StIdle;
                        status_d = StatIdle;
                        intrq_d  = 1'b1;
                    end
                end else if (!store_wr_q) begin
                    store_wr_d  = 1'b1;
                    store_out_d = buf_q[ptr_q];
                end
            end
            default: state_d = StIdle;
        endcase

        // Soft reset overrides everything in flight, including a same-cycle store ack
        if (devctrl_d[2]) begin
            state_d    = StIdle;
            status_d   = StatSrst;
            store_rd_d = 1'b0;
            store_wr_d = 1'b0;
            buf_we     = 1'b0;
            ptr_d      = 8'd0;
            cnt_d      = 9'd0;
        end else if (devctrl_q[2]) begin
            status_d = StatIdle;
            error_d  = 8'h01;
        end
    end

    // Control and task-file state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            status_q    <= StatIdle;
            error_q     <= 8'h00;
            feature_q   <= 8'h00;
            seccnt_q    <= 8'h01;
            lba_lo_q    <= 8'h00;
            lba_mid_q   <= 8'h00;
            lba_hi_q    <= 8'h00;
            drvhead_q   <= 8'h00;
            command_q   <= 8'h00;
            devctrl_q   <= 8'h00;
            intrq_q     <= 1'b0;
            ptr_q       <= 8'd0;
            cnt_q       <= 9'd0;
            cmd_lba_q   <= '0;
            store_rd_q  <= 1'b0;
            store_wr_q  <= 1'b0;
            store_out_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            error_q     <= error_d;
            feature_q   <= feature_d;
            seccnt_q    <= seccnt_d;
            lba_lo_q    <= lba_lo_d;
            lba_mid_q   <= lba_mid_d;
            lba_hi_q    <= lba_hi_d;
            drvhead_q   <= drvhead_d;
            command_q   <= command_d;
            devctrl_q   <= devctrl_d;
            intrq_q     <= intrq_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            cmd_lba_q   <= cmd_lba_d;
            store_rd_q  <= store_rd_d;
            store_wr_q  <= store_wr_d;
            store_out_q <= store_out_d;
        end
    end

    // Sector buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[ptr_q] <= buf_wdata;
    end

    assign store_addr = {cmd_lba_q, ptr_q};
    assign store_rd   = store_rd_q;
    assign store_wr   = store_wr_q;
    assign store_out  = store_out_q;
    assign busy       = status_q[7];

    // Feature, nIEN and the interrupt flag are held but have no external effect
    assign unused_regs = ^{feature_q, devctrl_q[7:3], devctrl_q[1:0], intrq_q};

endmodule

// File: tb/tb_ide_target.sv
// Self-checking bench for ide_target: register vectors, sector read/write, aborts, stalls,
// soft reset, async reset, and randomized sectors against a behavioural disk model.
module tb_ide_target;

    localparam logic [4:0] RegData    = 5'b10000;
    localparam logic [4:0] RegErr     = 5'b10001;
    localparam logic [4:0] RegSecCnt  = 5'b10010;
    localparam logic [4:0] RegLbaLo   = 5'b10011;
    localparam logic [4:0] RegLbaMid  = 5'b10100;
    localparam logic [4:0] RegLbaHi   = 5'b10101;
    localparam logic [4:0] RegDrvHead = 5'b10110;
    localparam logic [4:0] RegStatus  = 5'b10111;
    localparam logic [4:0] RegCtrl    = 5'b01110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    wire  [15:0] ide_data_bus;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_dout = 16'h0000;
    logic        ide_dior = 1'b1;
    logic        ide_diow = 1'b1;
    logic [1:0]  ide_cs = 2'b11;
    logic [2:0]  ide_da = 3'b000;
    logic [23:0] store_addr;
    logic        store_rd, store_wr;
    logic [15:0] store_out;
    logic [15:0] store_in;
    logic        store_ack;
    logic        busy;

    always #5 clk = ~clk;
    assign ide_data_bus = tb_drv ? tb_dout : 16'hzzzz;

    ide_target #(.LBA_BITS(16), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .ide_data_bus (ide_data_bus),
        .ide_dior     (ide_dior),
        .ide_diow     (ide_diow),
        .ide_cs       (ide_cs),
        .ide_da       (ide_da),
        .store_addr   (store_addr),
        .store_rd     (store_rd),
        .store_wr     (store_wr),
        .store_out    (store_out),
        .store_in     (store_in),
        .store_ack    (store_ack),
        .busy         (busy)
    );

    typedef struct {
        logic [23:0] a;
        logic [15:0] d;
    } acc_t;

    bit [15:0]   store_mem [int unsigned];
    bit [15:0]   exp_mem   [int unsigned];
    logic [23:0] rd_log [$];
    acc_t        wr_log [$];
    int          stall_cycles = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [15:0] sect [256];

    // Backing store: acks each request after stall_cycles, one request at a time
    initial begin : store_model
        int wcnt;
        wcnt = 0;
        store_ack = 1'b0;
        store_in = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            store_ack = 1'b0;
            if (reset) begin
                wcnt = 0;
            end else if (store_rd || store_wr) begin
                if (wcnt < stall_cycles) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    store_ack = 1'b1;
                    if (store_rd) begin
                        store_in = store_mem[32'(store_addr)];
                        rd_log.push_back(store_addr);
                        n_rd++;
                    end else begin
                        store_mem[32'(store_addr)] = store_out;
                        wr_log.push_back('{a: store_addr, d: store_out});
                        n_wr++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [4:0] addr, input logic [15:0] data);
        @(negedge clk);
        {ide_cs, ide_da} = addr;
        tb_dout = data;
        tb_drv = 1'b1;
        @(negedge clk);
        ide_diow = 1'b0;
        repeat (4) @(negedge clk);
        ide_diow = 1'b1;
        repeat (4) @(negedge clk);
        tb_drv = 1'b0;
        ide_cs = 2'b11;
    endtask

    task automatic host_rd(input logic [4:0] addr, output logic [15:0] data);
        @(negedge clk);
        {ide_cs, ide_da} = addr;
        @(negedge clk);
        ide_dior = 1'b0;
        repeat (4) @(negedge clk);
        data = ide_data_bus;
        ide_dior = 1'b1;
        repeat (4) @(negedge clk);
        ide_cs = 2'b11;
    endtask

    task automatic host_cmd(input logic [23:0] lba, input logic [7:0] dh, input logic [7:0] sc,
                            input logic [7:0] cmd);
        host_wr(RegSecCnt, {8'h00, sc});
        host_wr(RegLbaLo, {8'h00, lba[7:0]});
        host_wr(RegLbaMid, {8'h00, lba[15:8]});
        host_wr(RegLbaHi, {8'h00, lba[23:16]});
        host_wr(RegDrvHead, {8'h00, dh});
        host_wr(RegStatus, {8'h00, cmd});
    endtask

    // Poll status until BSY clears; when strict, every busy poll must read 0xD0
    task automatic poll_idle(input string name, input bit strict, output logic [15:0] st);
        int n;
        n = 0;
        host_rd(RegStatus, st);
        while (st[7] && n < 4000) begin
            if (strict) check({name, " busy poll"}, 32'(st), 32'h00D0);
            host_rd(RegStatus, st);
            n++;
        end
        if (st[7]) check({name, " bsy timeout"}, 32'(st), 32'h0000);
    endtask

    task automatic read_sector_check(input string name, input logic [23:0] lba);
        logic [15:0] rd;
        for (int i = 0; i < 256; i++) begin
            host_rd(RegData, rd);
            check($sformatf("%s word %0d", name, i), 32'(rd),
                  32'(exp_mem[32'(lba) * 256 + 32'(i)]));
        end
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [23:0] lba;
        logic [7:0]  sc;
        logic [7:0]  cmd;
    } abort_t;

    initial begin : main
        vec_t        vec [18];
        abort_t      ab [3];
        logic [15:0] rd;
        logic [15:0] st;
        logic [23:0] lba;
        logic [7:0]  dh;
        bit          ok;
        int          nr, nw, n;

        vec[0]  = '{wr: 1'b0, addr: RegStatus,  data: 16'h0050};
        vec[1]  = '{wr: 1'b0, addr: RegErr,     data: 16'h0000};
        vec[2]  = '{wr: 1'b0, addr: RegCtrl,    data: 16'h0050};
        vec[3]  = '{wr: 1'b0, addr: RegSecCnt,  data: 16'h0001};
        vec[4]  = '{wr: 1'b0, addr: RegLbaLo,   data: 16'h0000};
        vec[5]  = '{wr: 1'b0, addr: RegDrvHead, data: 16'h0000};
        vec[6]  = '{wr: 1'b1, addr: RegSecCnt,  data: 16'h00A7};
        vec[7]  = '{wr: 1'b0, addr: RegSecCnt,  data: 16'h00A7};
        vec[8]  = '{wr: 1'b1, addr: RegLbaLo,   data: 16'hFF34};
        vec[9]  = '{wr: 1'b0, addr: RegLbaLo,   data: 16'h0034};
        vec[10] = '{wr: 1'b1, addr: RegLbaMid,  data: 16'h0012};
        vec[11] = '{wr: 1'b0, addr: RegLbaMid,  data: 16'h0012};
        vec[12] = '{wr: 1'b1, addr: RegLbaHi,   data: 16'h0056};
        vec[13] = '{wr: 1'b0, addr: RegLbaHi,   data: 16'h0056};
        vec[14] = '{wr: 1'b1, addr: RegDrvHead, data: 16'h00E0};
        vec[15] = '{wr: 1'b0, addr: RegDrvHead, data: 16'h00E0};
        vec[16] = '{wr: 1'b0, addr: RegData,    data: 16'h0000};
        vec[17] = '{wr: 1'b0, addr: RegStatus,  data: 16'h0050};

        ab[0] = '{lba: 24'h000123, sc: 8'h01, cmd: 8'hEC};
        ab[1] = '{lba: 24'h000123, sc: 8'h02, cmd: 8'h20};
        ab[2] = '{lba: 24'h010000, sc: 8'h01, cmd: 8'h20};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state: outputs idle
        check("reset busy", 32'(busy), 32'h0);
        check("reset store_rd", 32'(store_rd), 32'h0);
        check("reset store_wr", 32'(store_wr), 32'h0);
        check("reset store_out", 32'(store_out), 32'h0);

        // Bus released when no read strobe: host-driven value must be seen unaltered
        {ide_cs, ide_da} = RegStatus;
        tb_dout = 16'h0A0A;
        tb_drv = 1'b1;
        repeat (4) @(negedge clk);
        check("bus released", 32'(ide_data_bus), 32'h0A0A);
        tb_drv = 1'b0;
        ide_cs = 2'b11;

        // Register vectors
        for (int i = 0; i < 18; i++) begin
            if (vec[i].wr) begin
                host_wr(vec[i].addr, vec[i].data);
            end else begin
                host_rd(vec[i].addr, rd);
                check($sformatf("vec %0d reg %05b", i, vec[i].addr), 32'(rd), 32'(vec[i].data));
            end
        end

        // READ SECTOR at LBA 0x123
        for (int i = 0; i < 256; i++) begin
            store_mem[32'h12300 + 32'(i)] = 16'h0A00 + 16'(i);
            exp_mem[32'h12300 + 32'(i)] = 16'h0A00 + 16'(i);
        end
        rd_log.delete();
        host_cmd(24'h000123, 8'h40, 8'h01, 8'h20);
        poll_idle("read", 1'b1, st);
        check("read drq status", 32'(st), 32'h0058);
        check("read store count", 32'(rd_log.size()), 32'd256);
        for (int i = 0; i < rd_log.size() && i < 256; i++)
            check($sformatf("read addr %0d", i), 32'(rd_log[i]), 32'h12300 + 32'(i));
        read_sector_check("read", 24'h000123);
        host_rd(RegStatus, st);
        check("read final status", 32'(st), 32'h0050);
        host_rd(RegData, rd);
        check("data read idle", 32'(rd), 32'h0000);

        // WRITE SECTOR at LBA 5, plus a 257th write that must be dropped
        wr_log.delete();
        host_cmd(24'h000005, 8'h40, 8'h01, 8'h30);
        host_rd(RegStatus, st);
        check("write drq status", 32'(st), 32'h0058);
        for (int i = 0; i < 256; i++) host_wr(RegData, 16'h1000 + 16'(i));
        host_wr(RegData, 16'hDEAD);
        poll_idle("write", 1'b0, st);
        check("write final status", 32'(st), 32'h0050);
        check("write store count", 32'(wr_log.size()), 32'd256);
        for (int i = 0; i < wr_log.size() && i < 256; i++) begin
            check($sformatf("write addr %0d", i), 32'(wr_log[i].a), 32'h00500 + 32'(i));
            check($sformatf("write data %0d", i), 32'(wr_log[i].d), 32'h1000 + 32'(i));
        end
        for (int i = 0; i < 256; i++) exp_mem[32'h500 + 32'(i)] = 16'h1000 + 16'(i);

        // Aborted commands: no store traffic
        for (int k = 0; k < 3; k++) begin
            nr = n_rd;
            nw = n_wr;
            host_cmd(ab[k].lba, 8'h40, ab[k].sc, ab[k].cmd);
            poll_idle($sformatf("abort %0d", k), 1'b0, st);
            check($sformatf("abort %0d status", k), 32'(st), 32'h0051);
            host_rd(RegErr, rd);
            check($sformatf("abort %0d error", k), 32'(rd), 32'h0004);
            check($sformatf("abort %0d store rd", k), 32'(n_rd), 32'(nr));
            check($sformatf("abort %0d store wr", k), 32'(n_wr), 32'(nw));
        end

        // Stalled store during FETCH
        for (int i = 0; i < 256; i++) begin
            store_mem[32'hABCD00 + 32'(i)] = 16'hC000 ^ 16'(i * 7);
            exp_mem[32'hABCD00 + 32'(i)] = 16'hC000 ^ 16'(i * 7);
        end
        stall_cycles = 50;
        host_cmd(24'h00ABCD, 8'h40, 8'h01, 8'h20);
        for (int k = 0; k < 4; k++) begin
            repeat (500) @(negedge clk);
            check($sformatf("stall busy pin %0d", k), 32'(busy), 32'h1);
        end
        poll_idle("stall", 1'b1, st);
        check("stall drq status", 32'(st), 32'h0058);
        stall_cycles = 0;
        read_sector_check("stall", 24'h00ABCD);
        host_rd(RegStatus, st);
        check("stall final status", 32'(st), 32'h0050);

        // Soft reset in the middle of XFER_IN
        host_cmd(24'h000123, 8'h40, 8'h01, 8'h20);
        poll_idle("srst", 1'b0, st);
        check("srst drq status", 32'(st), 32'h0058);
        for (int i = 0; i < 10; i++) begin
            host_rd(RegData, rd);
            check($sformatf("srst word %0d", i), 32'(rd), 32'h0A00 + 32'(i));
        end
        host_wr(RegCtrl, 16'h0004);
        host_rd(RegCtrl, rd);
        check("srst altstatus", 32'(rd), 32'h0080);
        check("srst busy pin", 32'(busy), 32'h1);
        host_wr(RegCtrl, 16'h0000);
        host_rd(RegStatus, st);
        check("srst release status", 32'(st), 32'h0050);
        host_rd(RegErr, rd);
        check("srst release error", 32'(rd), 32'h0001);
        host_rd(RegData, rd);
        check("srst data after", 32'(rd), 32'h0000);

        // Async reset in the middle of FLUSH
        stall_cycles = 50;
        host_cmd(24'h000007, 8'h40, 8'h01, 8'h30);
        for (int i = 0; i < 256; i++) host_wr(RegData, 16'h7700 + 16'(i));
        n = 0;
        while (!store_wr && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("flush store_wr up", 32'(store_wr), 32'h1);
        repeat (20) @(negedge clk);
        nw = n_wr;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset drops store_wr", 32'(store_wr), 32'h0);
        check("reset drops busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        stall_cycles = 0;
        repeat (100) @(negedge clk);
        check("no store wr after reset", 32'(n_wr), 32'(nw));
        host_rd(RegStatus, st);
        check("status after reset", 32'(st), 32'h0050);

        // Randomized sectors against the disk model
        for (int it = 0; it < 4; it++) begin
            lba = 24'($urandom_range(0, 32'h13FFF));
            dh = ($urandom_range(0, 3) == 0) ? 8'h50 : 8'h40;
            ok = (32'(lba) < 32'h10000) && !dh[4];
            for (int i = 0; i < 256; i++) sect[i] = 16'($urandom);
            wr_log.delete();
            host_cmd(lba, dh, 8'h01, 8'h30);
            host_rd(RegStatus, st);
            if (!ok) begin
                check($sformatf("rnd %0d abort status", it), 32'(st), 32'h0051);
                host_rd(RegErr, rd);
                check($sformatf("rnd %0d abort error", it), 32'(rd), 32'h0004);
                continue;
            end
            check($sformatf("rnd %0d write drq", it), 32'(st), 32'h0058);
            for (int i = 0; i < 256; i++) host_wr(RegData, sect[i]);
            poll_idle("rnd write", 1'b0, st);
            check($sformatf("rnd %0d write done", it), 32'(st), 32'h0050);
            check($sformatf("rnd %0d wr count", it), 32'(wr_log.size()), 32'd256);
            for (int i = 0; i < wr_log.size() && i < 256; i++) begin
                check($sformatf("rnd %0d wr addr %0d", it, i), 32'(wr_log[i].a),
                      32'(lba) * 256 + 32'(i));
                check($sformatf("rnd %0d wr data %0d", it, i), 32'(wr_log[i].d), 32'(sect[i]));
            end
            for (int i = 0; i < 256; i++) exp_mem[32'(lba) * 256 + 32'(i)] = sect[i];
            host_cmd(lba, dh, 8'h01, 8'h20);
            poll_idle("rnd read", 1'b0, st);
            check($sformatf("rnd %0d read drq", it), 32'(st), 32'h0058);
            read_sector_check($sformatf("rnd %0d", it), lba);
            host_rd(RegStatus, st);
            check($sformatf("rnd %0d read done", it), 32'(st), 32'h0050);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
